// File: rtl/ahb_bus_arbiter_if.sv
// Bus-side signals of the AHB arbiter, grouped for the master agents (master)
// and the arbiter itself (slave). FSM state and beat count are exported for checkers.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic [2:0]             hburst;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MW-1:0]          hmaster;
    logic [MW-1:0]          hmaster_data;
    logic                   hmastlock;
    logic [1:0]             dbg_state;
    logic [3:0]             dbg_beat_cnt;

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmaster_data, hmastlock, dbg_state, dbg_beat_cnt
    );

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmaster_data, hmastlock, dbg_state, dbg_beat_cnt
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with default master, fixed-burst protection and
// locked-transfer support. Ownership only moves on an accepted beat (hready=1).
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic              hclk,
    input  logic              hrst,
    ahb_bus_arbiter_if.slave  bus
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_INCR   = 3'b001;

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             beat_cnt_q, beat_cnt_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic [MW-1:0]          hmaster_data_q, hmaster_data_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;

    logic          accept;
    logic          is_fixed;
    logic [3:0]    burst_last;
    logic          cur_lock;
    logic          keep_owner;
    logic          handover;
    logic          rr_found;
    logic [MW-1:0] rr_owner;
    logic [MW-1:0] rr_idx;

    always_comb begin
        accept   = bus.hready;
        is_fixed = (bus.hburst[2:1] != 2'b00);
        case (bus.hburst[2:1])
            2'b01:   burst_last = 4'd3;
            2'b10:   burst_last = 4'd7;
            2'b11:   burst_last = 4'd15;
            default: burst_last = 4'd0;
        endcase
        cur_lock   = bus.hlock[hmaster_q];
        keep_owner = bus.hbusreq[hmaster_q] && (bus.hburst == BU_INCR) &&
                     ((bus.htrans == TR_NONSEQ) || (bus.htrans == TR_SEQ));

        // Scan hmaster+1 upwards with wrap; the current owner is tried last.
        rr_found = 1'b0;
        rr_owner = DEF_IDX;
        rr_idx   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            rr_idx = MW'((int'(hmaster_q) + i) % NUM_MASTERS);
            if (!rr_found && bus.hbusreq[rr_idx]) begin
                rr_found = 1'b1;
                rr_owner = rr_idx;
            end
        end

        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            case (state_q)
                ST_ARB: begin
                    if (bus.htrans == TR_NONSEQ && cur_lock) begin
                        state_d    = ST_LOCKED;
                        beat_cnt_d = is_fixed ? burst_last : 4'd0;
                    end else if (bus.htrans == TR_NONSEQ && is_fixed) begin
                        state_d    = ST_BURST;
                        beat_cnt_d = burst_last;
                    end else begin
                        beat_cnt_d = 4'd0;
                    end
                end
                ST_BURST: begin
                    case (bus.htrans)
                        TR_SEQ: begin
                            if (beat_cnt_q <= 4'd1) begin
                                state_d    = ST_ARB;
                                beat_cnt_d = 4'd0;
                            end else begin
                                beat_cnt_d = beat_cnt_q - 4'd1;
                            end
                        end
                        TR_BUSY: ;
                        default: begin
                            state_d    = ST_ARB;
                            beat_cnt_d = 4'd0;
                        end
                    endcase
                end
                ST_LOCKED: begin
                    // Release only between bursts, once the master drops hlock.
                    if (!cur_lock && beat_cnt_q == 4'd0 && bus.htrans != TR_BUSY) begin
                        state_d    = ST_ARB;
                        beat_cnt_d = 4'd0;
                    end else begin
                        case (bus.htrans)
                            TR_SEQ:    beat_cnt_d = (beat_cnt_q != 4'd0) ? beat_cnt_q - 4'd1 : 4'd0;
                            TR_NONSEQ: beat_cnt_d = is_fixed ? burst_last : 4'd0;
                            TR_IDLE:   beat_cnt_d = 4'd0;
                            default:   beat_cnt_d = beat_cnt_q;
                        endcase
                    end
                end
                default: begin
                    state_d    = ST_ARB;
                    beat_cnt_d = 4'd0;
                end
            endcase
        end

        hmastlock_d = accept ? (state_d == ST_LOCKED) : hmastlock_q;
        handover    = accept && (state_d == ST_ARB) && !hmastlock_d;

        hmaster_d = hmaster_q;
        if (handover) begin
            hmaster_d = keep_owner ? hmaster_q : rr_owner;
        end
        hgrant_d       = NUM_MASTERS'(1) << hmaster_d;
        hmaster_data_d = accept ? hmaster_q : hmaster_data_q;
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q        <= ST_ARB;
            beat_cnt_q     <= 4'd0;
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
            hmastlock_q    <= 1'b0;
            hgrant_q       <= DEF_GRANT;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            hmastlock_q    <= hmastlock_d;
            hgrant_q       <= hgrant_d;
        end
    end

    assign bus.hgrant       = hgrant_q;
    assign bus.hmaster      = hmaster_q;
    assign bus.hmaster_data = hmaster_data_q;
    assign bus.hmastlock    = hmastlock_q;
    assign bus.dbg_state    = state_q;
    assign bus.dbg_beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed, table-driven bench for ahb_bus_arbiter (4 masters, default master 0)
// plus a hand-written asynchronous-reset sequence in the middle of an INCR8.
module tb_ahb_bus_arbiter;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BY = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;
    localparam logic [2:0] SGL  = 3'b000;
    localparam logic [2:0] INCR = 3'b001;
    localparam logic [2:0] I4   = 3'b011;
    localparam logic [2:0] W8   = 3'b100;
    localparam logic [2:0] I8   = 3'b101;
    localparam logic [2:0] I16  = 3'b111;
    localparam logic [1:0] A = 2'd0;
    localparam logic [1:0] B = 2'd1;
    localparam logic [1:0] L = 2'd2;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       rdy;
        logic [1:0] e_m;
        logic [1:0] e_md;
        logic       e_lk;
        logic [1:0] e_st;
        logic [3:0] e_cnt;
    } vec_t;

    logic hclk;
    logic hrst;
    int   n_tests;
    int   n_fail;
    vec_t tbl[$];

    ahb_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

    ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .hclk (hclk),
        .hrst (hrst),
        .bus  (bus.slave)
    );

    // clock / reset
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    function automatic vec_t mk(logic [3:0] req, logic [3:0] lock, logic [1:0] trans,
                                logic [2:0] burst, logic rdy, logic [1:0] e_m,
                                logic [1:0] e_md, logic e_lk, logic [1:0] e_st,
                                logic [3:0] e_cnt);
        vec_t v;
        v.req = req; v.lock = lock; v.trans = trans; v.burst = burst; v.rdy = rdy;
        v.e_m = e_m; v.e_md = e_md; v.e_lk = e_lk; v.e_st = e_st; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_m, input logic [1:0] e_md,
                             input logic e_lk, input logic [1:0] e_st, input logic [3:0] e_cnt);
        logic [3:0] e_gnt;
        e_gnt = 4'b0001 << e_m;
        check({tag, " hmaster"},      32'(bus.hmaster),      32'(e_m));
        check({tag, " hgrant"},       32'(bus.hgrant),       32'(e_gnt));
        check({tag, " hmaster_data"}, 32'(bus.hmaster_data), 32'(e_md));
        check({tag, " hmastlock"},    32'(bus.hmastlock),    32'(e_lk));
        check({tag, " state"},        32'(bus.dbg_state),    32'(e_st));
        check({tag, " beat_cnt"},     32'(bus.dbg_beat_cnt), 32'(e_cnt));
    endtask

    // driver: inputs change 1 time unit after the edge, outputs sampled likewise
    task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                         input logic [2:0] burst, input logic rdy);
        bus.hbusreq = req;
        bus.hlock   = lock;
        bus.htrans  = trans;
        bus.hburst  = burst;
        bus.hready  = rdy;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        hrst = 1'b1;
        bus.hbusreq = '0; bus.hlock = '0; bus.htrans = ID; bus.hburst = SGL; bus.hready = 1'b0;

        // round robin 1,2,3,1,2
        tbl.push_back(mk(4'b1110, 4'b0000, NS, SGL, 1'b1, 2'd1, 2'd0, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b1110, 4'b0000, NS, SGL, 1'b1, 2'd2, 2'd1, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b1110, 4'b0000, NS, SGL, 1'b1, 2'd3, 2'd2, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b1110, 4'b0000, NS, SGL, 1'b1, 2'd1, 2'd3, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b1110, 4'b0000, NS, SGL, 1'b1, 2'd2, 2'd1, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b0010, 4'b0000, ID, SGL, 1'b1, 2'd1, 2'd2, 1'b0, A, 4'd0));
        // INCR4 with a BUSY beat, M2 waiting
        tbl.push_back(mk(4'b0110, 4'b0000, NS, I4,  1'b1, 2'd1, 2'd1, 1'b0, B, 4'd3));
        tbl.push_back(mk(4'b0110, 4'b0000, SQ, I4,  1'b1, 2'd1, 2'd1, 1'b0, B, 4'd2));
        tbl.push_back(mk(4'b0110, 4'b0000, BY, I4,  1'b1, 2'd1, 2'd1, 1'b0, B, 4'd2));
        tbl.push_back(mk(4'b0110, 4'b0000, SQ, I4,  1'b1, 2'd1, 2'd1, 1'b0, B, 4'd1));
        tbl.push_back(mk(4'b0110, 4'b0000, SQ, I4,  1'b1, 2'd2, 2'd1, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b0110, 4'b0000, ID, SGL, 1'b0, 2'd2, 2'd1, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b0110, 4'b0000, ID, SGL, 1'b1, 2'd1, 2'd2, 1'b0, A, 4'd0));
        // WRAP8 terminated after 3 beats, stalled twice
        tbl.push_back(mk(4'b0110, 4'b0000, NS, W8,  1'b1, 2'd1, 2'd1, 1'b0, B, 4'd7));
        tbl.push_back(mk(4'b0110, 4'b0000, SQ, W8,  1'b1, 2'd1, 2'd1, 1'b0, B, 4'd6));
        tbl.push_back(mk(4'b0110, 4'b0000, SQ, W8,  1'b1, 2'd1, 2'd1, 1'b0, B, 4'd5));
        tbl.push_back(mk(4'b0110, 4'b0000, ID, W8,  1'b0, 2'd1, 2'd1, 1'b0, B, 4'd5));
        tbl.push_back(mk(4'b0110, 4'b0000, ID, W8,  1'b0, 2'd1, 2'd1, 1'b0, B, 4'd5));
        tbl.push_back(mk(4'b0110, 4'b0000, ID, W8,  1'b1, 2'd2, 2'd1, 1'b0, A, 4'd0));
        // locked M3 through two INCR4 bursts, M0 waiting
        tbl.push_back(mk(4'b1000, 4'b1000, ID, SGL, 1'b1, 2'd3, 2'd2, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b1001, 4'b1000, NS, I4,  1'b1, 2'd3, 2'd3, 1'b1, L, 4'd3));
        tbl.push_back(mk(4'b1001, 4'b1000, SQ, I4,  1'b1, 2'd3, 2'd3, 1'b1, L, 4'd2));
        tbl.push_back(mk(4'b1001, 4'b1000, SQ, I4,  1'b1, 2'd3, 2'd3, 1'b1, L, 4'd1));
        tbl.push_back(mk(4'b1001, 4'b1000, SQ, I4,  1'b1, 2'd3, 2'd3, 1'b1, L, 4'd0));
        tbl.push_back(mk(4'b1001, 4'b1000, NS, I4,  1'b1, 2'd3, 2'd3, 1'b1, L, 4'd3));
        tbl.push_back(mk(4'b1001, 4'b1000, SQ, I4,  1'b1, 2'd3, 2'd3, 1'b1, L, 4'd2));
        tbl.push_back(mk(4'b1001, 4'b1000, SQ, I4,  1'b1, 2'd3, 2'd3, 1'b1, L, 4'd1));
        tbl.push_back(mk(4'b1001, 4'b1000, SQ, I4,  1'b1, 2'd3, 2'd3, 1'b1, L, 4'd0));
        tbl.push_back(mk(4'b1001, 4'b0000, ID, SGL, 1'b1, 2'd0, 2'd3, 1'b0, A, 4'd0));
        // idle bus falls back to the default master
        tbl.push_back(mk(4'b0100, 4'b0000, ID, SGL, 1'b1, 2'd2, 2'd0, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b0000, 4'b0000, NS, SGL, 1'b1, 2'd0, 2'd2, 1'b0, A, 4'd0));
        // undefined-length INCR hold, then release when the request drops
        tbl.push_back(mk(4'b0011, 4'b0000, NS, INCR, 1'b1, 2'd0, 2'd0, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b0011, 4'b0000, SQ, INCR, 1'b1, 2'd0, 2'd0, 1'b0, A, 4'd0));
        tbl.push_back(mk(4'b0010, 4'b0000, SQ, INCR, 1'b1, 2'd1, 2'd0, 1'b0, A, 4'd0));
        // INCR16 count load, early NONSEQ termination
        tbl.push_back(mk(4'b0110, 4'b0000, NS, I16, 1'b1, 2'd1, 2'd1, 1'b0, B, 4'd15));
        tbl.push_back(mk(4'b0110, 4'b0000, NS, SGL, 1'b1, 2'd2, 2'd1, 1'b0, A, 4'd0));

        #12;
        check_all("reset", 2'd0, 2'd0, 1'b0, A, 4'd0);
        @(negedge hclk);
        hrst = 1'b0;
        @(posedge hclk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].burst, tbl[i].rdy);
            check_all($sformatf("vec%0d", i), tbl[i].e_m, tbl[i].e_md, tbl[i].e_lk,
                      tbl[i].e_st, tbl[i].e_cnt);
        end

        // asynchronous reset in the middle of an INCR8 owned by M1
        drive(4'b0010, 4'b0000, ID, SGL, 1'b1);
        check_all("pre_rst_own", 2'd1, 2'd2, 1'b0, A, 4'd0);
        drive(4'b0010, 4'b0000, NS, I8, 1'b1);
        drive(4'b0010, 4'b0000, SQ, I8, 1'b1);
        check_all("mid_incr8", 2'd1, 2'd1, 1'b0, B, 4'd6);
        #3;
        hrst = 1'b1;
        #1;
        check_all("async_rst", 2'd0, 2'd0, 1'b0, A, 4'd0);
        bus.hready = 1'b0;
        @(negedge hclk);
        hrst = 1'b0;
        @(posedge hclk);
        #1;
        check_all("post_rst", 2'd0, 2'd0, 1'b0, A, 4'd0);
        drive(4'b0100, 4'b0000, NS, SGL, 1'b1);
        check_all("post_rst_rr", 2'd2, 2'd0, 1'b0, A, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
